pin_lock_ctrl: RTL
==================

Name: pin_lock_ctrl

Overview:
Digit-serial PIN lock controller, the next generation of the team's lock system. Replaces the parallel setpin/inpin compare with keypad-style digit entry, a PIN stored internally and reprogrammable, a parametrised attempt limit and a timed lockout. It sits between the keypad scanner (digit strobes) and the door actuator and alarm driver.

Parameters:
DIGITS, 4, number of digits in a PIN (>=1)
DIGIT_W, 4, bits per digit
DEFAULT_PIN, 16'h1234, stored PIN after reset; width DIGITS*DIGIT_W, first-entered digit in the MS digit
MAX_TRIES, 3, consecutive wrong entries that trigger lockout (>=1)
ACCESS_CYC, 4, cycles access is held after a correct entry (>=1)
LOCKOUT_CYC, 16, cycles of lockout (>=1)
CNT_W, 2, width of fail_count; must satisfy 2^CNT_W > MAX_TRIES

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
digit_valid  in  1  one-cycle strobe: digit is a new key press
digit  in  DIGIT_W  key value
clear  in  1  discard the partial entry
enter  in  1  submit the entry for comparison
set_pin  in  1  while granted, store the current entry as the new PIN
access  out  1  unlock, held ACCESS_CYC cycles
alarm  out  1  wrong-entry alarm
locked  out  1  lockout active
fail_count  out  CNT_W  consecutive wrong entries
digit_count  out  $clog2(DIGITS+1)  digits currently buffered
pin_updated  out  1  one-cycle pulse: PIN reprogrammed

Behaviour:
- All outputs and state are registered. Inputs sampled at edge k are reflected in outputs after edge k.
- Reset (asynchronous, any time, including mid-grant or mid-lockout): state=IDLE, pin=DEFAULT_PIN. Entry buffer, digit_count, overflow flag, fail_count, timers, access, alarm, locked and pin_updated are all 0.
- Entry buffer (IDLE and GRANT states):
  - digit_valid with digit_count<DIGITS: shift the buffer left by DIGIT_W, insert digit, digit_count+1.
  - digit_valid with digit_count==DIGITS: the digit is dropped and the sticky ovf flag is set.
  - clear: buffer=0, digit_count=0, ovf=0.
- Same-cycle priority: reset > clear > enter/set_pin > digit_valid. A digit_valid in the same cycle as clear, enter or set_pin is dropped.
- IDLE state, enter asserted:
  - match = (digit_count==DIGITS) && !ovf && (buffer==pin).
  - The buffer, digit_count and ovf are cleared after every enter, whether it matches or not.
  - Match: go to GRANT. Set access=1, alarm=0, fail_count=0, and load the timer with ACCESS_CYC.
  - Mismatch with fail_count+1 < MAX_TRIES: fail_count+1, alarm=1, stay in IDLE.
  - Mismatch with fail_count+1 == MAX_TRIES: go to LOCKOUT. Set locked=1, alarm=1, fail_count=MAX_TRIES, and load the timer with LOCKOUT_CYC.
- alarm stays high from the first wrong entry until a correct entry, the end of a lockout, or reset.
- GRANT state:
  - access=1 for exactly ACCESS_CYC cycles, then return to IDLE with access=0 and the buffer cleared.
  - Digits and clear are accepted. enter is ignored.
  - set_pin with digit_count==DIGITS and !ovf: pin=buffer, pin_updated=1 for one cycle, buffer cleared. The grant timer is not restarted.
  - set_pin with an incomplete or overflowed buffer: ignored, no pulse, buffer kept.
  - set_pin in IDLE or LOCKOUT: ignored.
- LOCKOUT state:
  - digit_valid, clear, enter and set_pin are all ignored, and the buffer is held at 0.
  - After LOCKOUT_CYC cycles: go to IDLE with locked=0, alarm=0, fail_count=0.
- Timer: down-counter sized for max(ACCESS_CYC, LOCKOUT_CYC). Expiry occurs when the count reaches 1, so the state lasts exactly N cycles, N counted from the first cycle the output is high.
- MAX_TRIES=1: the first wrong entry goes directly to LOCKOUT.

Test Plan:
(Defaults throughout, except LOCKOUT_CYC=8.)
- Correct entry: keys 1,2,3,4 then enter -> access=1 for exactly 4 cycles, fail_count=0, alarm=0, digit_count returns to 0.
- Lockout: keys 1,2,3,5 + enter, then short 1,2,3 + enter, then 5 keys 1,2,3,4,4 (ovf) + enter -> fail_count 1,2 with alarm=1, then locked=1 and fail_count=3. Digits and enter are ignored for 8 cycles. Then locked=0, alarm=0, fail_count=0, and 1,2,3,4 + enter grants.
- Recovery: one wrong entry (fail_count=1, alarm=1), then 1,2,3,4 + enter -> access=1, alarm=0, fail_count=0.
- Reprogram: grant, then keys 9,8,7,6 + set_pin inside the window -> pin_updated pulses once. After the grant ends, 1,2,3,4 + enter increments fail_count and 9,8,7,6 + enter grants. set_pin in IDLE changes nothing.
- Priority: digit_valid together with enter -> the digit is dropped and the compare uses the prior buffer. clear mid-entry then 1,2,3,4 + enter -> grant.
- Asynchronous reset mid-lockout and mid-grant -> all outputs 0 immediately without a clock edge, and pin restored to 16'h1234.

Source files
------------

// File: rtl/pin_lock_ctrl.sv
// pin_lock_ctrl: digit-serial PIN lock with reprogrammable stored PIN,
// consecutive-failure counting, timed access grant and timed lockout.
module pin_lock_ctrl #(
  parameter int                              DIGITS      = 4,
  parameter int                              DIGIT_W     = 4,
  parameter logic [DIGITS*DIGIT_W-1:0]       DEFAULT_PIN = 16'h1234,
  parameter int                              MAX_TRIES   = 3,
  parameter int                              ACCESS_CYC  = 4,
  parameter int                              LOCKOUT_CYC = 16,
  parameter int                              CNT_W       = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         digit_valid,
  input  logic [DIGIT_W-1:0]           digit,
  input  logic                         clear,
  input  logic                         enter,
  input  logic                         set_pin,
  output logic                         access,
  output logic                         alarm,
  output logic                         locked,
  output logic [CNT_W-1:0]             fail_count,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         pin_updated
);
  localparam int PW   = DIGITS * DIGIT_W;
  localparam int DCW  = $clog2(DIGITS + 1);
  localparam int TMAX = ACCESS_CYC > LOCKOUT_CYC ? ACCESS_CYC : LOCKOUT_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  typedef enum logic [1:0] {IDLE, GRANT, LOCKOUT} state_t;
  state_t          r_state;
  logic [PW-1:0]   r_pin;
  logic [PW-1:0]   r_buf;
  logic            r_ovf;
  logic [TW-1:0]   r_timer;
  logic            w_full;
  logic            w_ok;
  logic            w_match;
  logic            w_expire;
  logic            w_last_try;
  assign w_full     = digit_count == DCW'(DIGITS);
  assign w_ok       = w_full && !r_ovf;
  assign w_match    = w_ok && (r_buf == r_pin);
  assign w_expire   = r_timer == TW'(1);
  assign w_last_try = int'(fail_count) + 1 >= MAX_TRIES;
  // Later assignments in the body override earlier ones, so grant expiry
  // always leaves the buffer empty regardless of what else happened that cycle.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state     <= IDLE;
      r_pin       <= DEFAULT_PIN;
      r_buf       <= '0;
      r_ovf       <= 1'b0;
      r_timer     <= '0;
      digit_count <= '0;
      fail_count  <= '0;
      access      <= 1'b0;
      alarm       <= 1'b0;
      locked      <= 1'b0;
      pin_updated <= 1'b0;
    end else begin
      pin_updated <= 1'b0;
      if (r_state == LOCKOUT) begin
        if (w_expire) begin
          r_state    <= IDLE;
          locked     <= 1'b0;
          alarm      <= 1'b0;
          fail_count <= '0;
        end else r_timer <= r_timer - TW'(1);
      end else begin
        if (clear) begin
          r_buf       <= '0;
          digit_count <= '0;
          r_ovf       <= 1'b0;
        end else if (enter && r_state == IDLE) begin
          r_buf       <= '0;
          digit_count <= '0;
          r_ovf       <= 1'b0;
          if (w_match) begin
            r_state    <= GRANT;
            access     <= 1'b1;
            alarm      <= 1'b0;
            fail_count <= '0;
            r_timer    <= TW'(ACCESS_CYC);
          end else if (w_last_try) begin
            r_state    <= LOCKOUT;
            locked     <= 1'b1;
            alarm      <= 1'b1;
            fail_count <= CNT_W'(MAX_TRIES);
            r_timer    <= TW'(LOCKOUT_CYC);
          end else begin
            fail_count <= fail_count + 1'b1;
            alarm      <= 1'b1;
          end
        end else if (set_pin && r_state == GRANT && w_ok) begin
          r_pin       <= r_buf;
          pin_updated <= 1'b1;
          r_buf       <= '0;
          digit_count <= '0;
        end else if (digit_valid && !enter && !set_pin) begin
          if (!w_full) begin
            r_buf       <= (r_buf << DIGIT_W) | PW'(digit);
            digit_count <= digit_count + 1'b1;
          end else r_ovf <= 1'b1;
        end
        if (r_state == GRANT) begin
          if (w_expire) begin
            r_state     <= IDLE;
            access      <= 1'b0;
            r_buf       <= '0;
            digit_count <= '0;
            r_ovf       <= 1'b0;
          end else r_timer <= r_timer - TW'(1);
        end
      end
    end
endmodule
